dram_arbiter: RTL and testbench

Two-client arbiter and sequencer in front of the single-port-pair DRAM model (clk, ren, wen, raddr, waddr, wdata, rdata).
- Accepts independent read/write requests from two requesters and grants them round-robin.
- Issues exactly one registered DRAM command per cycle and routes returned read data to the owning client by a latency-matched tag pipe.
- Enforces a periodic refresh blackout during which no commands are issued.

---
 rtl/dram_pkg.sv | 16 +
 rtl/dram_arbiter_tag_pipe.sv | 39 +++
 rtl/dram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and defaults for the two-client DRAM arbiter.
package dram_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 8;

    // Sequencer state: normal service or refresh blackout.
    typedef enum logic {
        Serve   = 1'b0,
        Refresh = 1'b1
    } state_t;

    // Requester identifier (two clients).
    typedef logic client_id_t;

endpackage

// File: rtl/dram_arbiter_tag_pipe.sv
// Read-return tag pipe: delays {valid, client id} by DEPTH cycles so the tag
// lines up with the DRAM read data it belongs to.
module rd_tag_pipe
    import dram_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  client_id_t in_id,
    output logic       out_valid,
    output client_id_t out_id
);

    logic [DEPTH-1:0] valid_q;
    client_id_t       id_q [DEPTH];

    // Shift register; reset drops every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                id_q[i] <= 1'b0;
            end
        end else begin
            valid_q[0] <= in_valid;
            id_q[0]    <= in_id;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/dram_arbiter.sv
// Two-client round-robin arbiter and command sequencer in front of a DRAM
// with separate read and write ports. One registered command per cycle, with
// a periodic refresh blackout during which nothing is granted.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned REF_PERIOD = 64,
    parameter int unsigned REF_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ref_active
);

    localparam int unsigned CNT_MAX = (REF_PERIOD > REF_CYCLES) ? REF_PERIOD : REF_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t            state;
    logic [CNT_W-1:0]  ref_cnt;
    client_id_t        last_gnt;
    client_id_t        issue_id;

    logic              period_end;
    logic              grant_ok;
    logic              any_gnt;
    client_id_t        win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              tag_valid;
    client_id_t        tag_id;

    // The last SERVE cycle of a period is reserved so refresh starts cleanly.
    assign period_end = (ref_cnt == CNT_W'(REF_PERIOD - 1));
    assign grant_ok   = (state == Serve) && !period_end;

    // Round-robin grant: on conflict the client that did not win last time goes.
    always_comb begin
        c0_gnt = 1'b0;
        c1_gnt = 1'b0;
        if (grant_ok) begin
            if (c0_req && c1_req) begin
                c0_gnt = (last_gnt == 1'b1);
                c1_gnt = (last_gnt == 1'b0);
            end else begin
                c0_gnt = c0_req;
                c1_gnt = c1_req;
            end
        end
    end

    // Winner's command mux.
    always_comb begin
        any_gnt   = c0_gnt | c1_gnt;
        win_id    = c1_gnt;
        win_we    = c1_gnt ? c1_we    : c0_we;
        win_addr  = c1_gnt ? c1_addr  : c0_addr;
        win_wdata = c1_gnt ? c1_wdata : c0_wdata;
    end

    // Refresh sequencer FSM with registered ref_active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= Serve;
            ref_cnt    <= '0;
            ref_active <= 1'b0;
        end else begin
            unique case (state)
                Serve: begin
                    if (period_end) begin
                        state      <= Refresh;
                        ref_cnt    <= '0;
                        ref_active <= 1'b1;
                    end else begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                Refresh: begin
                    if (ref_cnt == CNT_W'(REF_CYCLES - 1)) begin
                        state      <= Serve;
                        ref_cnt    <= '0;
                        ref_active <= 1'b0;
                    end else begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= Serve;
                    ref_cnt    <= '0;
                    ref_active <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer; starts at 1 so client 0 wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (any_gnt) begin
            last_gnt <= win_id;
        end
    end

    // Command issue register; address/data hold when no matching command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            issue_id  <= 1'b0;
        end else begin
            mem_ren <= any_gnt && !win_we;
            mem_wen <= any_gnt && win_we;
            if (any_gnt) begin
                issue_id <= win_id;
            end
            if (any_gnt && !win_we) begin
                mem_raddr <= win_addr;
            end
            if (any_gnt && win_we) begin
                mem_waddr <= win_addr;
                mem_wdata <= win_wdata;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_ren),
        .in_id     (issue_id),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    assign c0_rvalid = tag_valid && (tag_id == 1'b0);
    assign c1_rvalid = tag_valid && (tag_id == 1'b1);
    assign c0_rdata  = mem_rdata;
    assign c1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: DRAM model, cycle-level reference
// model with per-cycle compare, and directed scenarios with literal checks.
module tb_dram_arbiter;

    localparam int unsigned AW     = 20;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned P      = 64;
    localparam int unsigned C      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
    logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          mem_ren, mem_wen, ref_active;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LAT     (RD_LAT),
        .REF_PERIOD (P),
        .REF_CYCLES (C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c0_req     (c0_req),
        .c0_we      (c0_we),
        .c0_addr    (c0_addr),
        .c0_wdata   (c0_wdata),
        .c0_gnt     (c0_gnt),
        .c0_rvalid  (c0_rvalid),
        .c0_rdata   (c0_rdata),
        .c1_req     (c1_req),
        .c1_we      (c1_we),
        .c1_addr    (c1_addr),
        .c1_wdata   (c1_wdata),
        .c1_gnt     (c1_gnt),
        .c1_rvalid  (c1_rvalid),
        .c1_rdata   (c1_rdata),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ref_active (ref_active)
    );

    // Unwritten locations read back as a fixed function of the address.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // DRAM model: RD_LAT-cycle read pipe, write lands on the command edge.
    logic [DW-1:0] dram [int];
    logic [DW-1:0] rd_dly [RD_LAT];
    always @(posedge clk) begin
        logic [DW-1:0] v;
        v = dram.exists(int'(mem_raddr)) ? dram[int'(mem_raddr)] : init_val(mem_raddr);
        if (mem_ren) rd_dly[0] <= v;
        for (int i = 1; i < int'(RD_LAT); i++) rd_dly[i] <= rd_dly[i-1];
        if (mem_wen) dram[int'(mem_waddr)] = mem_wdata;
    end
    assign mem_rdata = rd_dly[RD_LAT-1];

    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } ret_t;

    logic          m_last = 1'b1;
    logic          e_ren = 0, e_wen = 0;
    logic [AW-1:0] e_raddr = '0, e_waddr = '0;
    logic [DW-1:0] e_wdata = '0;
    ret_t          retq [$];
    logic [DW-1:0] mdl_mem [int];

    logic          gnt_log [$];
    logic [DW-1:0] r0_log [$];
    logic [DW-1:0] r1_log [$];
    int            first_ref = -1;
    int            ref_hi = 0;

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
        return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : init_val(a);
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_ren", mem_ren, 0);
            chk("rst_mem_wen", mem_wen, 0);
            chk("rst_mem_raddr", mem_raddr, 0);
            chk("rst_mem_waddr", mem_waddr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_c0_rvalid", c0_rvalid, 0);
            chk("rst_c1_rvalid", c1_rvalid, 0);
            chk("rst_ref_active", ref_active, 0);
            cyc    = 0;
            m_last = 1'b1;
            e_ren  = 0;
            e_wen  = 0;
            retq.delete();
        end else begin
            int            pos;
            logic          g0, g1, x0, x1, id, we;
            logic [AW-1:0] a;
            logic [DW-1:0] d, xd;
            ret_t          r;
            pos = cyc % int'(P + C);
            g0  = 0;
            g1  = 0;
            if (pos < int'(P) - 1) begin
                if (c0_req && c1_req) begin
                    g0 = m_last;
                    g1 = !m_last;
                end else begin
                    g0 = c0_req;
                    g1 = c1_req;
                end
            end
            chk("c0_gnt", c0_gnt, g0);
            chk("c1_gnt", c1_gnt, g1);
            chk("ref_active", ref_active, (pos >= int'(P)) ? 1 : 0);
            chk("mem_ren", mem_ren, e_ren);
            chk("mem_wen", mem_wen, e_wen);
            if (e_ren) chk("mem_raddr", mem_raddr, e_raddr);
            if (e_wen) begin
                chk("mem_waddr", mem_waddr, e_waddr);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            x0 = 0;
            x1 = 0;
            xd = '0;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                r = retq.pop_front();
                if (r.id) x1 = 1; else x0 = 1;
                xd = r.data;
            end
            chk("c0_rvalid", c0_rvalid, x0);
            chk("c1_rvalid", c1_rvalid, x1);
            if (x0) chk("c0_rdata", c0_rdata, xd);
            if (x1) chk("c1_rdata", c1_rdata, xd);
            if (c0_rvalid) r0_log.push_back(c0_rdata);
            if (c1_rvalid) r1_log.push_back(c1_rdata);
            if (ref_active) begin
                if (first_ref < 0) first_ref = cyc;
                ref_hi++;
            end
            // Schedule what the next cycles must show.
            e_ren = 0;
            e_wen = 0;
            if (g0 || g1) begin
                id = g1;
                we = id ? c1_we : c0_we;
                a  = id ? c1_addr : c0_addr;
                d  = id ? c1_wdata : c0_wdata;
                m_last = id;
                gnt_log.push_back(id);
                if (we) begin
                    e_wen   = 1;
                    e_waddr = a;
                    e_wdata = d;
                    mdl_mem[int'(a)] = d;
                end else begin
                    e_ren   = 1;
                    e_raddr = a;
                    r.due   = cyc + 1 + int'(RD_LAT);
                    r.id    = id;
                    r.data  = mdl_read(a);
                    retq.push_back(r);
                end
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise a request, hold it until granted (bounded), then drop it.
    task automatic do_req(input logic c, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int waited);
        logic got;
        if (c) begin
            c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d;
        end else begin
            c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = d;
        end
        waited = 0;
        got    = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (c ? c1_gnt : c0_gnt) begin
                got = 1;
                break;
            end
            waited++;
        end
        chk("grant_within_budget", got, 1);
        @(posedge clk);
        #1;
        c0_req = 0;
        c1_req = 0;
    endtask

    initial begin
        int w, n0, n1;
        logic hit;

        // Reset, then idle across the first refresh window
        step(3);
        rst = 0;
        step(70);
        chk("first_ref_cycle", first_ref, 64);
        chk("ref_len", ref_hi, 4);

        // Lone c0 read of address 1
        n0 = r0_log.size();
        n1 = r1_log.size();
        do_req(0, 0, 20'h00001, 8'h00, w);
        chk("c0_read_wait", w, 0);
        step(3);
        chk("c0_read_count", r0_log.size(), n0 + 1);
        chk("c0_read_data", r0_log[$], 8'h5B);
        chk("c1_no_rvalid", r1_log.size(), n1);

        // Both clients read continuously: grants alternate starting with c1
        gnt_log.delete();
        n0 = r0_log.size();
        n1 = r1_log.size();
        c0_req = 1; c0_we = 0; c0_addr = 20'h00002;
        c1_req = 1; c1_we = 0; c1_addr = 20'hD7E1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        c0_req = 0;
        c1_req = 0;
        step(3);
        chk("alt_grant_count", gnt_log.size(), 8);
        if (gnt_log.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("alt_grant_id", gnt_log[i], (i % 2 == 0) ? 1 : 0);
        end
        chk("alt_c0_count", r0_log.size(), n0 + 4);
        chk("alt_c1_count", r1_log.size(), n1 + 4);
        chk("alt_c0_data", r0_log[$], 8'h58);
        chk("alt_c1_data", r1_log[$], 8'hBB);

        // c1 write then c0 read-back of the same address
        do_req(1, 1, 20'hD7E2, 8'hA5, w);
        do_req(0, 0, 20'hD7E2, 8'h00, w);
        step(3);
        chk("wr_rd_data", r0_log[$], 8'hA5);

        // Read just before refresh, then a request held across the blackout
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (cyc % int'(P + C) == 62) begin
                hit = 1;
                break;
            end
            step(1);
        end
        chk("reach_pre_refresh", hit, 1);
        c0_req = 1; c0_we = 0; c0_addr = 20'h00003;
        @(negedge clk);
        chk("pre_refresh_grant", c0_gnt, 1);
        step(1);
        c0_req = 0;
        c1_req = 1; c1_we = 0; c1_addr = 20'h00004;
        w = 0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c1_gnt) begin
                hit = 1;
                break;
            end
            w++;
        end
        chk("held_grant_seen", hit, 1);
        chk("held_grant_wait", w, 5);
        step(1);
        c1_req = 0;
        step(3);
        chk("pre_refresh_read_data", r0_log[$], 8'h59);
        chk("post_refresh_read_data", r1_log[$], 8'h5E);

        // Reset with a read in flight
        do_req(0, 0, 20'h00005, 8'h00, w);
        n0 = r0_log.size();
        rst = 1;
        #1;
        chk("async_mem_ren", mem_ren, 0);
        chk("async_c0_rvalid", c0_rvalid, 0);
        chk("async_ref_active", ref_active, 0);
        step(2);
        rst = 0;
        step(4);
        chk("no_stale_rvalid", r0_log.size(), n0);
        gnt_log.delete();
        c0_req = 1; c0_we = 0; c0_addr = 20'h00006;
        c1_req = 1; c1_we = 0; c1_addr = 20'h00007;
        @(negedge clk);
        step(1);
        c0_req = 0;
        c1_req = 0;
        step(3);
        chk("post_rst_first_grant_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) chk("post_rst_first_grant", gnt_log[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
